// File: rtl/mul_div_sequencer.sv
// Fixed-latency iterative multiplier/divider: one shift-add or restoring
// shift-subtract step per cycle, with sign fix-ups folded into the final edge.
module mul_div_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             Start,
  input  logic [1:0]       MCycleOp,
  input  logic [WIDTH-1:0] Operand1,
  input  logic [WIDTH-1:0] Operand2,
  output logic [WIDTH-1:0] Result1,
  output logic [WIDTH-1:0] Result2,
  output logic             Busy,
  output logic             Done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    COMPUTE = 2'b01,
    DONE    = 2'b10
  } state_t;

  state_t             state_r, state_next_s;
  logic [CW-1:0]      count_r;
  logic [2*WIDTH-1:0] acc_r, acc_step_s, acc_load_s, prod_s;
  logic [WIDTH-1:0]   mcand_r, mcand_load_s;
  logic [WIDTH-1:0]   abs1_s, abs2_s, res1_s, res2_s, res1_r, res2_r;
  logic [WIDTH:0]     add_s, shift_s, diff_s;
  logic               is_div_r, neg_main_r, neg_rem_r, div_zero_r;
  logic               neg_main_s, neg_rem_s, sgn_s;
  logic               start_take_s, last_s;
  logic               busy_r, done_r;

  function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v, input logic signed_en);
    logic [WIDTH-1:0] r;
    if (signed_en && v[WIDTH-1]) begin
      r = -v;
    end else begin
      r = v;
    end
    return r;
  endfunction

  // State register
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state decode; a new request is only taken outside COMPUTE
  always_comb begin
    state_next_s = state_r;
    start_take_s = 1'b0;
    last_s       = (count_r == CNT_LAST);
    case (state_r)
      IDLE, DONE: begin
        if (Start) begin
          state_next_s = COMPUTE;
          start_take_s = 1'b1;
        end else begin
          state_next_s = IDLE;
        end
      end
      COMPUTE: begin
        if (last_s) begin
          state_next_s = DONE;
        end else begin
          state_next_s = COMPUTE;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Operand conditioning: magnitudes into the datapath, signs kept for the fix-up
  always_comb begin
    sgn_s      = ~MCycleOp[0];
    abs1_s     = abs_val(Operand1, sgn_s);
    abs2_s     = abs_val(Operand2, sgn_s);
    neg_main_s = sgn_s & (Operand1[WIDTH-1] ^ Operand2[WIDTH-1]);
    if (MCycleOp[1]) begin
      acc_load_s   = {{WIDTH{1'b0}}, abs1_s};
      mcand_load_s = abs2_s;
      neg_rem_s    = sgn_s & Operand1[WIDTH-1];
    end else begin
      acc_load_s   = {{WIDTH{1'b0}}, abs2_s};
      mcand_load_s = abs1_s;
      neg_rem_s    = 1'b0;
    end
  end

  // One iteration plus the sign fix-up applied to the last iteration's value
  always_comb begin
    add_s   = {1'b0, acc_r[2*WIDTH-1:WIDTH]};
    shift_s = {acc_r[2*WIDTH-1:WIDTH], acc_r[WIDTH-1]};
    diff_s  = shift_s - {1'b0, mcand_r};
    if (is_div_r) begin
      if (!diff_s[WIDTH]) begin
        acc_step_s = {diff_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b1};
      end else begin
        acc_step_s = {shift_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b0};
      end
    end else begin
      if (acc_r[0]) begin
        add_s = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + {1'b0, mcand_r};
      end else begin
        add_s = {1'b0, acc_r[2*WIDTH-1:WIDTH]};
      end
      acc_step_s = {add_s, acc_r[WIDTH-1:1]};
    end

    if (neg_main_r) begin
      prod_s = -acc_step_s;
    end else begin
      prod_s = acc_step_s;
    end

    if (is_div_r) begin
      // Divide-by-zero quotient is pinned; remainder fix-up restores Operand1 on its own
      if (div_zero_r) begin
        res1_s = {WIDTH{1'b1}};
      end else if (neg_main_r) begin
        res1_s = -acc_step_s[WIDTH-1:0];
      end else begin
        res1_s = acc_step_s[WIDTH-1:0];
      end
      if (neg_rem_r) begin
        res2_s = -acc_step_s[2*WIDTH-1:WIDTH];
      end else begin
        res2_s = acc_step_s[2*WIDTH-1:WIDTH];
      end
    end else begin
      res1_s = prod_s[WIDTH-1:0];
      res2_s = prod_s[2*WIDTH-1:WIDTH];
    end
  end

  // Datapath: latch on accept, iterate in COMPUTE, publish results on the last step
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      count_r    <= {CW{1'b0}};
      acc_r      <= {(2*WIDTH){1'b0}};
      mcand_r    <= {WIDTH{1'b0}};
      is_div_r   <= 1'b0;
      neg_main_r <= 1'b0;
      neg_rem_r  <= 1'b0;
      div_zero_r <= 1'b0;
      res1_r     <= {WIDTH{1'b0}};
      res2_r     <= {WIDTH{1'b0}};
    end else if (start_take_s) begin
      count_r    <= {CW{1'b0}};
      acc_r      <= acc_load_s;
      mcand_r    <= mcand_load_s;
      is_div_r   <= MCycleOp[1];
      neg_main_r <= neg_main_s;
      neg_rem_r  <= neg_rem_s;
      div_zero_r <= (Operand2 == {WIDTH{1'b0}});
    end else if (state_r == COMPUTE) begin
      count_r <= count_r + CNT_ONE;
      acc_r   <= acc_step_s;
      if (last_s) begin
        res1_r <= res1_s;
        res2_r <= res2_s;
      end
    end
  end

  // Registered status flags track the state being entered
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= (state_next_s == COMPUTE);
      done_r <= (state_next_s == DONE);
    end
  end

  assign Result1 = res1_r;
  assign Result2 = res2_r;
  assign Busy    = busy_r;
  assign Done    = done_r;

endmodule

// File: tb/tb_mul_div_sequencer.sv
// Self-checking bench for mul_div_sequencer: arithmetic reference model checked
// every cycle, plus directed vectors with hand-computed results.
module tb_mul_div_sequencer;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        Start;
  logic [1:0]  MCycleOp;
  logic [31:0] Operand1, Operand2;
  logic [31:0] Result1, Result2;
  logic        Busy, Done;

  int checks = 0;
  int errors = 0;

  mul_div_sequencer #(.WIDTH(32)) dut (
    .CLK(CLK), .RESET(RESET), .Start(Start), .MCycleOp(MCycleOp),
    .Operand1(Operand1), .Operand2(Operand2),
    .Result1(Result1), .Result2(Result2), .Busy(Busy), .Done(Done)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic: returns {Result2, Result1}
  function automatic logic [63:0] ref_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb;
    logic signed [31:0] q, r;
    logic [63:0] res;
    sa = $signed(a);
    sb = $signed(b);
    case (op)
      2'b00: res = sa * sb;
      2'b01: res = {32'd0, a} * {32'd0, b};
      2'b10: begin
        if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) res = {32'd0, 32'h8000_0000};
        else begin
          q = $signed(a) / $signed(b);
          r = $signed(a) % $signed(b);
          res = {r, q};
        end
      end
      default: begin
        if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
        else res = {a % b, a / b};
      end
    endcase
    return res;
  endfunction

  // Behavioural timeline model: 32 busy cycles, then a one-cycle Done with results
  logic [31:0] m_r1 = 32'd0, m_r2 = 32'd0;
  logic [63:0] pend = 64'd0;
  logic        m_busy = 1'b0, m_done = 1'b0;
  int          m_left = 0;
  bit          cmp_en = 1'b0;

  always @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      m_left = 0; m_busy = 1'b0; m_done = 1'b0; m_r1 = 32'd0; m_r2 = 32'd0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_done = 1'b1; m_busy = 1'b0; {m_r2, m_r1} = pend;
      end
    end else begin
      m_done = 1'b0;
      if (Start) begin
        pend = ref_op(MCycleOp, Operand1, Operand2);
        m_left = 32; m_busy = 1'b1;
      end else begin
        m_busy = 1'b0;
      end
    end
  end

  always @(negedge CLK) begin
    if (cmp_en) begin
      chk("model_busy", {63'd0, Busy}, {63'd0, m_busy});
      chk("model_done", {63'd0, Done}, {63'd0, m_done});
      chk("model_result1", {32'd0, Result1}, {32'd0, m_r1});
      chk("model_result2", {32'd0, Result2}, {32'd0, m_r2});
    end
  end

  task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] e1, input logic [31:0] e2,
                        input int glitch_at);
    int busy_n, done_n, done_at;
    busy_n = 0; done_n = 0; done_at = 0;
    @(negedge CLK);
    Start = 1'b1; MCycleOp = op; Operand1 = a; Operand2 = b;
    for (int n = 1; n <= 40; n++) begin
      @(negedge CLK);
      Start = (n == glitch_at);
      if (n == glitch_at) begin
        Operand1 = ~a; Operand2 = b + 32'd1; MCycleOp = ~op;
      end
      if (Busy) busy_n++;
      if (Done) begin
        done_n++;
        if (done_at == 0) begin
          done_at = n;
          chk({name, "_r1"}, {32'd0, Result1}, {32'd0, e1});
          chk({name, "_r2"}, {32'd0, Result2}, {32'd0, e2});
        end
      end
    end
    chk({name, "_busy_cycles"}, 64'(busy_n), 64'd32);
    chk({name, "_done_cycle"}, 64'(done_at), 64'd33);
    chk({name, "_done_count"}, 64'(done_n), 64'd1);
  endtask

  initial begin
    int first_done, second_done, done_n;
    RESET = 1'b1; Start = 1'b0; MCycleOp = 2'b00; Operand1 = 32'd0; Operand2 = 32'd0;
    #1;
    chk("reset_busy", {63'd0, Busy}, 64'd0);
    chk("reset_done", {63'd0, Done}, 64'd0);
    chk("reset_result1", {32'd0, Result1}, 64'd0);
    chk("reset_result2", {32'd0, Result2}, 64'd0);
    @(negedge CLK);
    @(negedge CLK);
    RESET = 1'b0;
    cmp_en = 1'b1;

    run_op("umul_7x6",        2'b01, 32'd7,          32'd6,          32'd42,         32'd0,          0);
    run_op("smul_m1xm1",      2'b00, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0001,  32'h0000_0000,  0);
    run_op("umul_max",        2'b01, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0001,  32'hFFFF_FFFE,  0);
    run_op("smul_m3x5",       2'b00, 32'hFFFF_FFFD,  32'd5,          32'hFFFF_FFF1,  32'hFFFF_FFFF,  0);
    run_op("smul_min_sq",     2'b00, 32'h8000_0000,  32'h8000_0000,  32'h0000_0000,  32'h4000_0000,  0);
    run_op("sdiv_m7_2",       2'b10, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  0);
    run_op("sdiv_7_m2",       2'b10, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          0);
    run_op("udiv_100_7",      2'b11, 32'd100,        32'd7,          32'd14,         32'd2,          0);
    run_op("udiv_max_3",      2'b11, 32'hFFFF_FFFF,  32'd3,          32'h5555_5555,  32'd0,          0);
    run_op("udiv_by_zero",    2'b11, 32'd100,        32'd0,          32'hFFFF_FFFF,  32'd100,        0);
    run_op("sdiv_by_zero",    2'b10, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFF,  32'hFFFF_FFFB,  0);
    run_op("sdiv_overflow",   2'b10, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          0);
    run_op("umul_restart_ig", 2'b01, 32'h8000_0000,  32'd2,          32'd0,          32'd1,          5);

    // Back-to-back: second Start presented during the DONE cycle
    first_done = 0; second_done = 0; done_n = 0;
    @(negedge CLK);
    Start = 1'b1; MCycleOp = 2'b01; Operand1 = 32'd3; Operand2 = 32'd5;
    for (int n = 1; n <= 80; n++) begin
      @(negedge CLK);
      Start = 1'b0;
      if (first_done != 0 && n == first_done + 1)
        chk("b2b_busy_next", {63'd0, Busy}, 64'd1);
      if (Done) begin
        done_n++;
        if (first_done == 0) begin
          first_done = n;
          chk("b2b_first_r1", {32'd0, Result1}, 64'd15);
          Start = 1'b1; MCycleOp = 2'b11; Operand1 = 32'd100; Operand2 = 32'd7;
        end else if (second_done == 0) begin
          second_done = n;
          chk("b2b_second_r1", {32'd0, Result1}, 64'd14);
          chk("b2b_second_r2", {32'd0, Result2}, 64'd2);
        end
      end
    end
    chk("b2b_second_done_cycle", 64'(second_done), 64'd66);
    chk("b2b_done_count", 64'(done_n), 64'd2);

    // Asynchronous reset in the middle of COMPUTE
    @(negedge CLK);
    Start = 1'b1; MCycleOp = 2'b00; Operand1 = 32'd9; Operand2 = 32'd9;
    for (int n = 1; n <= 10; n++) begin
      @(negedge CLK);
      Start = 1'b0;
    end
    #2 RESET = 1'b1;
    #1;
    chk("midreset_busy", {63'd0, Busy}, 64'd0);
    chk("midreset_done", {63'd0, Done}, 64'd0);
    chk("midreset_result1", {32'd0, Result1}, 64'd0);
    chk("midreset_result2", {32'd0, Result2}, 64'd0);
    @(negedge CLK);
    RESET = 1'b0;
    done_n = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge CLK);
      if (Done) done_n++;
    end
    chk("midreset_no_done", 64'(done_n), 64'd0);
    run_op("after_reset_umul", 2'b01, 32'd12, 32'd11, 32'd132, 32'd0, 0);

    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mul_div_sequencer.md
MUL_DIV_SEQUENCER -- requirements
Module: mul_div_sequencer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, the operand and result width; all values below assume 32.
REQ-002 The block SHALL have port CLK, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port RESET, input, 1, asynchronous active-high reset.
REQ-004 The block SHALL have port Start, input, 1, request to begin an operation.
REQ-005 The block SHALL have port MCycleOp, input, 2, operation select: 00 signed mul, 01 unsigned mul, 10 signed div, 11 unsigned div.
REQ-006 The block SHALL have port Operand1, input, 32, multiplicand or dividend.
REQ-007 The block SHALL have port Operand2, input, 32, multiplier or divisor.
REQ-008 The block SHALL have port Result1, output, 32, product low word or quotient.
REQ-009 The block SHALL have port Result2, output, 32, product high word or remainder.
REQ-010 The block SHALL have port Busy, output, 1, high while an operation is in progress.
REQ-011 The block SHALL have port Done, output, 1, one-cycle pulse when results become valid.

Function
REQ-012 The FSM SHALL have three states: IDLE, COMPUTE and DONE.
REQ-013 In IDLE or DONE, a rising edge with Start=1 SHALL latch Operand1, Operand2 and MCycleOp, clear the iteration counter to 0, and enter COMPUTE.
REQ-014 COMPUTE SHALL last exactly 32 cycles (counter 0..31), one iteration per cycle, with Busy=1 in every COMPUTE cycle and at no other time.
REQ-015 The edge ending counter=31 SHALL load Result1 and Result2 and enter DONE, giving Done=1 exactly 33 cycles after the Start edge and fixed latency for every op.
REQ-016 DONE SHALL last one cycle, then go to IDLE unless Start=1 at that edge, in which case it SHALL enter COMPUTE per REQ-013.
REQ-017 Start, operand and MCycleOp changes during COMPUTE SHALL be ignored; no request is queued.
REQ-018 Result1 and Result2 SHALL hold their values from DONE until the next DONE, and SHALL not change during COMPUTE.
REQ-019 Multiplication SHALL use iterative shift-add over a 64-bit accumulator, with Result2:Result1 equal to the full 64-bit product.
REQ-020 Signed multiplication SHALL operate on absolute values and negate the 64-bit product when the operand signs differ.
REQ-021 Division SHALL use restoring shift-subtract, one quotient bit per cycle.
REQ-022 Signed division SHALL truncate toward zero, with the remainder taking the sign of the dividend.
REQ-023 Division by zero SHALL give quotient 0xFFFFFFFF and remainder Operand1, for both signed and unsigned division.
REQ-024 Signed 0x80000000 / 0xFFFFFFFF SHALL give quotient 0x80000000 and remainder 0.
REQ-025 All sign fix-ups SHALL complete within the fixed latency of REQ-015.

Reset
REQ-026 RESET=1 SHALL immediately, without waiting for CLK, force IDLE, counter 0, Busy=0, Done=0, Result1=0 and Result2=0.
REQ-027 A RESET mid-COMPUTE SHALL abandon the operation with no Done pulse.
REQ-028 The first Start edge after RESET deasserts SHALL be accepted normally.

Verification
REQ-029 Unsigned mul, 7 x 6: Busy high 32 cycles, Done=1 on cycle 33, Result1=42, Result2=0.
REQ-030 Mul 0xFFFFFFFF x 0xFFFFFFFF: signed gives R1=0x00000001, R2=0x00000000; unsigned gives R1=0x00000001, R2=0xFFFFFFFE.
REQ-031 Signed div, -7 / 2: R1=0xFFFFFFFD, R2=0xFFFFFFFF; unsigned div 100 / 7: R1=14, R2=2.
REQ-032 Corner divisions: unsigned 100 / 0 gives R1=0xFFFFFFFF, R2=100; signed 0x80000000 / 0xFFFFFFFF gives R1=0x80000000, R2=0.
REQ-033 Start pulsed again at cycle 5 of a busy operation, with operands changed: first result unaffected, exactly one Done.
REQ-034 Start taken in the DONE cycle: back-to-back operation with Busy=1 on the next cycle.
REQ-035 RESET asserted at COMPUTE cycle 10, between clock edges: Busy, Done and results go to 0 at once, no Done follows, and the next Start completes correctly.
